// File: rtl/icache_sa.sv
// N-way set-associative instruction cache for the OTTER fetch stage.
// The lookup is combinational on PC; a miss stalls fetch while the line-fill FSM loads the line.
//
// state | meaning
// IDLE  | lookup on PC; a hit is served in the same cycle, a miss latches the line and picks a victim
// REQ   | MEM_REQ asserted with MEM_ADDR held until MEM_ACK is sampled
// FILL  | one word written per MEM_VALID beat, ascending; the last beat writes the tag and sets valid
// DONE  | one stall cycle so the re-lookup in IDLE hits; any pending flush is applied on exit
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      PC,
    input  logic             RD_EN,
    input  logic             FLUSH,
    output logic [31:0]      INSTR,
    output logic             HIT,
    output logic             STALL,
    output logic             MEM_REQ,
    output logic [31:0]      MEM_ADDR,
    input  logic             MEM_ACK,
    input  logic             MEM_VALID,
    input  logic [31:0]      MEM_RDATA,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [CNT_W-1:0] MISS_CNT
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
    state_t state_q, state_d;

    logic [31:0]      data_mem [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAY_W-1:0] vptr_q   [SETS];

    logic [31:0]      line_q;
    logic [OFF_W-1:0] beat_q;
    logic [WAY_W-1:0] vway_q;
    logic             vptr_used_q;
    logic             flush_pend_q;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx, fill_idx;
    logic [TAG_W-1:0] pc_tag, fill_tag;
    logic             pc_unused;

    assign pc_off    = PC[2 +: OFF_W];
    assign pc_idx    = PC[2 + OFF_W +: IDX_W];
    assign pc_tag    = PC[31 -: TAG_W];
    assign fill_idx  = line_q[2 + OFF_W +: IDX_W];
    assign fill_tag  = line_q[31 -: TAG_W];
    assign pc_unused = ^PC[1:0];

    logic             hit_any, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, victim_way;

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid_q[pc_idx][w] && tag_mem[w][pc_idx] == pc_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[pc_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : vptr_q[pc_idx];
    end

    logic miss_start, hit_count, fill_we, fill_last, clear_all;

    always_comb begin
        state_d    = state_q;
        miss_start = 1'b0;
        hit_count  = 1'b0;
        fill_we    = 1'b0;
        fill_last  = 1'b0;
        clear_all  = 1'b0;
        HIT        = 1'b0;
        STALL      = 1'b1;
        MEM_REQ    = 1'b0;
        INSTR      = '0;
        case (state_q)
            IDLE: begin
                STALL     = RD_EN && !hit_any;
                clear_all = FLUSH;
                if (RD_EN && hit_any) begin
                    HIT       = 1'b1;
                    hit_count = 1'b1;
                    INSTR     = data_mem[hit_way][pc_idx][pc_off];
                end else if (RD_EN) begin
                    miss_start = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK) state_d = FILL;
            end
            FILL: begin
                if (MEM_VALID) begin
                    fill_we = 1'b1;
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        fill_last = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                clear_all = flush_pend_q || FLUSH;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign MEM_ADDR = line_q;
    assign HIT_CNT  = hit_cnt_q;
    assign MISS_CNT = miss_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            line_q       <= '0;
            beat_q       <= '0;
            vway_q       <= '0;
            vptr_used_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                line_q      <= {PC[31:2+OFF_W], {(OFF_W+2){1'b0}}};
                beat_q      <= '0;
                vway_q      <= victim_way;
                vptr_used_q <= !inv_found;
            end
            if (fill_we) beat_q <= beat_q + OFF_W'(1);
            if (fill_last) begin
                valid_q[fill_idx][vway_q] <= 1'b1;
                // FIFO pointer only advances when it actually chose the victim
                if (vptr_used_q)
                    vptr_q[fill_idx] <= (vptr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0
                                        : vptr_q[fill_idx] + WAY_W'(1);
            end
            if (state_q != IDLE && FLUSH) flush_pend_q <= 1'b1;
            if (clear_all) begin
                flush_pend_q <= 1'b0;
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
            if (hit_count && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (miss_start && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_we) data_mem[vway_q][fill_idx][beat_q] <= MEM_RDATA;
        if (fill_last) tag_mem[vway_q][fill_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa (2 ways, 16 sets, 8-word lines, 4-bit counters).
// A small memory responder drives fills; lookup expectations go through a scoreboard queue.
module tb_icache_sa;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] PC = '0;
    logic        RD_EN = 1'b0;
    logic        FLUSH = 1'b0;
    logic [31:0] INSTR;
    logic        HIT, STALL, MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK = 1'b0;
    logic        MEM_VALID = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic [3:0]  HIT_CNT, MISS_CNT;

    icache_sa #(.WAYS(2), .SETS(16), .LINE_WORDS(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .PC(PC), .RD_EN(RD_EN), .FLUSH(FLUSH),
        .INSTR(INSTR), .HIT(HIT), .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_VALID(MEM_VALID), .MEM_RDATA(MEM_RDATA),
        .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    typedef struct {
        logic        hit;
        logic        stall;
        logic [31:0] instr;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic h, input logic s, input logic [31:0] i, input string n);
        exp_t e;
        e.hit = h; e.stall = s; e.instr = i; e.name = n;
        sb.push_back(e);
    endtask

    task automatic sample_cmp();
        exp_t e;
        @(negedge CLK);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue at sample");
        end else begin
            e = sb.pop_front();
            if (HIT !== e.hit || STALL !== e.stall || INSTR !== e.instr) begin
                errors++;
                $display("FAIL %s: HIT=%0b STALL=%0b INSTR=%h, expected HIT=%0b STALL=%0b INSTR=%h",
                         e.name, HIT, STALL, INSTR, e.hit, e.stall, e.instr);
            end
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic do_reset();
        RST_N = 1'b0; RD_EN = 1'b0; FLUSH = 1'b0; MEM_ACK = 1'b0; MEM_VALID = 1'b0;
        #2;
        chk("reset HIT", {31'b0, HIT}, 32'd0);
        chk("reset STALL", {31'b0, STALL}, 32'd0);
        chk("reset MEM_REQ", {31'b0, MEM_REQ}, 32'd0);
        chk("reset MEM_ADDR", MEM_ADDR, 32'd0);
        chk("reset HIT_CNT", {28'b0, HIT_CNT}, 32'd0);
        chk("reset MISS_CNT", {28'b0, MISS_CNT}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_hits = 0;
        exp_misses = 0;
        step();
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] instr, input logic flush, input string n);
        PC = pc; RD_EN = 1'b1; FLUSH = flush;
        push_exp(1'b1, 1'b0, instr, n);
        sample_cmp();
        exp_hits = sat(exp_hits);
        step();
        RD_EN = 1'b0; FLUSH = 1'b0;
    endtask

    // Miss on pc, then serve the fill; words are base+0..base+7.
    task automatic miss_fill(input logic [31:0] pc, input logic [31:0] base, input int ack_wait,
                             input int gaps, input int flush_beat, input string n);
        logic [31:0] line;
        int stalls, bad;
        line = {pc[31:5], 5'b0};
        stalls = 0;
        bad = 0;
        PC = pc; RD_EN = 1'b1;
        push_exp(1'b0, 1'b1, 32'd0, {n, " miss"});
        sample_cmp();
        exp_misses = sat(exp_misses);
        step();
        PC = pc ^ 32'h0000_4000;
        for (int k = 0; k <= ack_wait; k++) begin
            MEM_ACK = (k == ack_wait);
            @(negedge CLK);
            if (STALL === 1'b1) stalls++;
            if (MEM_REQ !== 1'b1 || MEM_ADDR !== line) bad++;
            step();
        end
        MEM_ACK = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                for (int g = 0; g < gaps; g++) begin
                    MEM_VALID = 1'b0;
                    @(negedge CLK);
                    if (STALL === 1'b1) stalls++;
                    if (MEM_REQ !== 1'b0) bad++;
                    step();
                end
            end
            MEM_VALID = 1'b1;
            MEM_RDATA = base + 32'(b);
            FLUSH = (b == flush_beat);
            @(negedge CLK);
            if (STALL === 1'b1) stalls++;
            if (MEM_REQ !== 1'b0) bad++;
            step();
        end
        MEM_VALID = 1'b0;
        FLUSH = 1'b0;
        @(negedge CLK);
        if (STALL === 1'b1) stalls++;
        step();
        chk({n, " stall cycles"}, 32'(stalls), 32'(2 + ack_wait + 8 + gaps));
        chk({n, " req/addr errors"}, 32'(bad), 32'd0);
        RD_EN = 1'b0;
        PC = pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].pc = 32'h100 + 32'(4 * i);
            vecs[i].instr = 32'hA0 + 32'(i);
        end

        do_reset();

        // basic miss, fill and hits
        miss_fill(32'h100, 32'hA0, 0, 0, -1, "t1");
        lookup(32'h100, 32'hA0, 1'b0, "t1 word0");
        lookup(32'h11C, 32'hA7, 1'b0, "t1 word7");
        chk("t1 HIT_CNT", {28'b0, HIT_CNT}, 32'd2);
        chk("t1 MISS_CNT", {28'b0, MISS_CNT}, 32'd1);
        RD_EN = 1'b0;
        push_exp(1'b0, 1'b0, 32'd0, "idle no fetch");
        sample_cmp();
        step();
        chk("idle HIT_CNT", {28'b0, HIT_CNT}, 32'(exp_hits));

        for (int i = 0; i < 8; i++) lookup(vecs[i].pc, vecs[i].instr, 1'b0, "table hit");
        chk("table HIT_CNT", {28'b0, HIT_CNT}, 32'(exp_hits));

        // flush in IDLE: same-cycle lookup still hits, then misses
        lookup(32'h104, 32'hA1, 1'b1, "t4 flush-cycle hit");
        miss_fill(32'h100, 32'hB0, 0, 0, 2, "t4 after idle flush");
        miss_fill(32'h100, 32'hC0, 0, 0, -1, "t4 after fill flush");
        lookup(32'h10C, 32'hC3, 1'b0, "t4 refilled");

        // ack and data wait states; hit counter saturates
        miss_fill(32'h200, 32'h300, 3, 2, -1, "t3");
        lookup(32'h200, 32'h300, 1'b0, "t3 word0");
        lookup(32'h21C, 32'h307, 1'b0, "t3 word7");
        lookup(32'h210, 32'h304, 1'b0, "t3 word4");
        lookup(32'h214, 32'h305, 1'b0, "t3 word5");
        chk("HIT_CNT saturated", {28'b0, HIT_CNT}, 32'd15);
        chk("t3 MISS_CNT", {28'b0, MISS_CNT}, 32'(exp_misses));

        // reset during beat 4 of a fill
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        PC = 32'h100; RD_EN = 1'b1;
        push_exp(1'b0, 1'b1, 32'd0, "t5 miss");
        sample_cmp();
        step();
        RD_EN = 1'b0;
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        for (int b = 0; b < 4; b++) begin
            MEM_VALID = 1'b1;
            MEM_RDATA = 32'hD0 + 32'(b);
            step();
        end
        MEM_RDATA = 32'hD4;
        RST_N = 1'b0;
        #1;
        chk("t5 MEM_REQ", {31'b0, MEM_REQ}, 32'd0);
        chk("t5 MEM_ADDR", MEM_ADDR, 32'd0);
        chk("t5 HIT_CNT", {28'b0, HIT_CNT}, 32'd0);
        chk("t5 MISS_CNT", {28'b0, MISS_CNT}, 32'd0);
        chk("t5 STALL", {31'b0, STALL}, 32'd0);
        MEM_VALID = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        miss_fill(32'h100, 32'hE0, 0, 0, -1, "t5 after reset");
        lookup(32'h110, 32'hE4, 1'b0, "t5 refilled");
        chk("t5 counts", {24'b0, HIT_CNT, MISS_CNT}, {24'b0, 4'd1, 4'd1});

        // FIFO replacement in set 0
        do_reset();
        miss_fill(32'h0000, 32'h10, 0, 0, -1, "t2 a");
        miss_fill(32'h0800, 32'h20, 0, 0, -1, "t2 b");
        miss_fill(32'h1000, 32'h30, 0, 0, -1, "t2 c");
        lookup(32'h0800, 32'h20, 1'b0, "t2 b kept");
        lookup(32'h1004, 32'h31, 1'b0, "t2 c hit");
        miss_fill(32'h0000, 32'h40, 0, 0, -1, "t2 a evicted");
        lookup(32'h1000, 32'h30, 1'b0, "t2 c kept");
        miss_fill(32'h0800, 32'h50, 0, 0, -1, "t2 b evicted");
        lookup(32'h0008, 32'h42, 1'b0, "t2 a refilled");

        // miss counter saturation
        do_reset();
        for (int i = 0; i < 16; i++) begin
            miss_fill(32'h4000 + 32'(i * 32'h20), 32'h1000 * 32'(i), 0, 0, -1, "t6");
            if (i == 13) chk("t6 MISS_CNT 14", {28'b0, MISS_CNT}, 32'd14);
        end
        chk("MISS_CNT saturated", {28'b0, MISS_CNT}, 32'd15);
        chk("t6 MISS_CNT model", {28'b0, MISS_CNT}, 32'(exp_misses));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
